// File: rtl/card_deck_loader.sv
// card_deck_loader: builds a shuffled pair deck in the card memory.
//   Pass 1 (CLEAR) writes EMPTY_VAL to the unused tail addresses NUM_CARDS..MEM_DEPTH-1.
//   Pass 2 (DRAW/PROBE) places cards 0..NUM_CARDS-1 with value k>>1.
//   Each card starts at an LFSR-chosen slot and probes linearly to the next free slot.
// Ports:
//   clock        - system clock, all logic on posedge
//   reset_n      - synchronous active-low reset
//   start        - one-cycle request to build a deck; accepted in IDLE only
//   busy         - high from the cycle after start is accepted until done
//   done         - one-cycle completion pulse
//   wr_en        - memory write strobe, valid for one cycle per write
//   wr_addr      - memory write address
//   wr_data      - memory write data
//   cards_placed - grid cards written so far in the current run
module card_deck_loader #(
  parameter int unsigned        NUM_CARDS = 36,
  parameter int unsigned        MEM_DEPTH = 64,
  parameter int unsigned        ADDR_W    = 6,
  parameter int unsigned        DATA_W    = 5,
  parameter logic [DATA_W-1:0]  EMPTY_VAL = 5'h1F,
  parameter logic [15:0]        LFSR_SEED = 16'hACE1,
  parameter bit                 RANDOMIZE = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [5:0]        cards_placed
);

  localparam int unsigned LFSR_W = 16;
  localparam int unsigned CNT_W  = 6;
  // With a full grid there is no tail to clear, so the CLEAR pass is skipped.
  localparam bit HAS_TAIL = (NUM_CARDS < MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    DRAW  = 3'd2,
    PROBE = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t                 state;
  logic [LFSR_W-1:0]      lfsr;
  logic                   lfsr_fb;
  logic [NUM_CARDS-1:0]   occ;
  logic [ADDR_W-1:0]      clear_ptr;
  logic [ADDR_W-1:0]      probe_ptr;
  logic [ADDR_W-1:0]      rand_slot;
  logic [ADDR_W-1:0]      draw_slot;
  logic [ADDR_W-1:0]      probe_next;
  logic [DATA_W-1:0]      card_val;
  logic                   last_card;
  logic                   last_clear;

  // Fibonacci feedback for taps 16,14,13,11.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Starting slot for the current card; a single subtraction folds 36..63 onto 0..27.
  always_comb begin
    rand_slot = lfsr[ADDR_W-1:0];
    if (rand_slot >= ADDR_W'(NUM_CARDS)) begin
      rand_slot = rand_slot - ADDR_W'(NUM_CARDS);
    end
    draw_slot = RANDOMIZE ? rand_slot : ADDR_W'(cards_placed);
  end

  // Linear probe step, wrapping at the end of the grid.
  assign probe_next = (probe_ptr == ADDR_W'(NUM_CARDS - 1)) ? '0
                                                            : probe_ptr + ADDR_W'(1);

  // Two consecutive cards share a value, giving NUM_CARDS/2 pairs.
  assign card_val   = DATA_W'(cards_placed >> 1);
  assign last_card  = (cards_placed == CNT_W'(NUM_CARDS - 1));
  assign last_clear = (clear_ptr == ADDR_W'(MEM_DEPTH - 1));

  // Control FSM; every output is a register. A write is registered in the cycle
  // that decides it and therefore presented to the memory in the following cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      occ          <= '0;
      clear_ptr    <= '0;
      probe_ptr    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cards_placed <= '0;
    end else begin
      // Free-running so the player's start timing perturbs the shuffle.
      lfsr  <= {lfsr[LFSR_W-2:0], lfsr_fb};
      wr_en <= 1'b0;
      done  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            occ          <= '0;
            cards_placed <= '0;
            if (HAS_TAIL) begin
              // First tail write goes out in the first CLEAR cycle.
              state     <= CLEAR;
              clear_ptr <= ADDR_W'(NUM_CARDS);
              wr_en     <= 1'b1;
              wr_addr   <= ADDR_W'(NUM_CARDS);
              wr_data   <= EMPTY_VAL;
            end else begin
              state <= DRAW;
            end
          end
        end

        CLEAR: begin
          // The write for clear_ptr is on the bus now; queue the next one.
          if (last_clear) begin
            state <= DRAW;
          end else begin
            clear_ptr <= clear_ptr + ADDR_W'(1);
            wr_en     <= 1'b1;
            wr_addr   <= clear_ptr + ADDR_W'(1);
            wr_data   <= EMPTY_VAL;
          end
        end

        DRAW: begin
          probe_ptr <= draw_slot;
          state     <= PROBE;
        end

        PROBE: begin
          if (occ[probe_ptr]) begin
            probe_ptr <= probe_next;
          end else begin
            occ[probe_ptr] <= 1'b1;
            wr_en          <= 1'b1;
            wr_addr        <= probe_ptr;
            wr_data        <= card_val;
            cards_placed   <= cards_placed + CNT_W'(1);
            if (last_card) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAW;
            end
          end
        end

        DONE: begin
          // done was registered on entry; the default above drops it again.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
